bf_code_loader: RTL
===================

Name: bf_code_loader

Overview:
- Upstream stage of the brainfuck core. Receives a program as a byte stream (e.g. from a UART receiver) and writes it into code RAM.
- Discards non-instruction bytes and checks bracket balance.
- Appends a 0x00 halt byte at the end of the program.
- Holds the core in reset until a valid program is fully loaded, then releases it.

Parameters:
- addrSize, 9, code RAM address width; must match the core's addrSize.
- depthSize, 8, width of the bracket-nesting counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset is asynchronous and active-low.
- load_start  input  1  single-cycle pulse; starts or restarts a load.
- rx_data  input  8  incoming program byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts the byte this cycle; transfer when rx_valid & rx_ready.
- code_addr  output  addrSize  code RAM write address.
- code_data  output  8  code RAM write data.
- code_we  output  1  code RAM write strobe, one cycle per write.
- core_reset  output  1  drives the core's active-low reset; 1 only in RUN.
- load_done  output  1  level; high in RUN.
- load_error  output  1  level; high in ERROR.
- err_code  output  2  01 = unmatched ']', 10 = unclosed '[', 11 = overflow, 00 = none.
- prog_len  output  addrSize  number of instructions stored, excluding the terminator.

Behaviour:
- Reset values: state IDLE; rx_ready=0, code_addr=0, code_data=0, code_we=0, core_reset=0, load_done=0, load_error=0, err_code=00, prog_len=0, depth=0.
- States: IDLE, LOAD, TERM, RUN, ERROR. All outputs are registered.
- IDLE/RUN/ERROR -> LOAD on load_start.
  - Clears the write pointer, depth, err_code, load_done and load_error; drives core_reset=0.
- LOAD:
  - rx_ready=1.
  - On each accepted byte:
    - Instruction bytes are 0x2B '+', 0x2D '-', 0x3C '<', 0x3E '>', 0x2E '.', 0x2C ',', 0x5B '[', 0x5D ']'.
    - Instruction byte: next cycle code_we=1, code_addr=ptr, code_data=byte; ptr increments.
    - 0x00: program end; go to TERM. rx_ready=0 from the next cycle.
    - Any other byte: discarded; no write, no state change.
  - '[' increments depth. If depth is at its maximum (all ones), go to ERROR with 11.
  - ']' with depth=0: go to ERROR with 01 and no write. Otherwise depth decrements.
  - Instruction accepted when ptr = 2^addrSize-1 (no room for the terminator): go to ERROR with 11 and no write.
- TERM (one cycle):
  - depth != 0: go to ERROR with 10.
  - Otherwise write 0x00 at ptr (code_we=1), set prog_len=ptr, and go to RUN.
- RUN: core_reset=1 and load_done=1. Bytes are not accepted (rx_ready=0).
- ERROR: rx_ready=0, core_reset=0, load_error=1. Only load_start or reset leaves this state.
- code_we is never high for two consecutive cycles with the same address.
- load_start while in LOAD restarts the load: ptr=0 and depth=0. The byte presented in that cycle is not accepted.
- Asynchronous reset mid-load: all outputs take their reset values immediately. RAM contents are undefined and are not cleared.
- Latency: a byte accepted at cycle N appears as code_we at N+1. Terminator write is one cycle after the 0x00 is accepted. core_reset rises on the cycle after the terminator write.

Decomposition:
- Shared package bf_pkg holds:
  - the instruction opcode constants (OP_INC 8'h2B, OP_DEC 8'h2D, OP_LEFT, OP_RIGHT, OP_OUT, OP_IN, OP_JZ, OP_JNZ, OP_HALT 8'h00);
  - the loader state enum;
  - the err_code constants.
  The core uses the same package for its case labels.
- One sub-module, bf_opcode_filter: combinational; from a byte it produces is_instr, is_open and is_close.

Test Plan:
- Stream "+-+" then 0x00 -> writes 0x2B@0, 0x2D@1, 0x2B@2, 0x00@3; prog_len=3; core_reset=1 one cycle after the 0x00@3 write.
- Stream "a+ \n-" then 0x00 -> only 0x2B@0, 0x2D@1, 0x00@2; 'a', ' ' and '\n' produce no code_we.
- Stream "+]" -> ERROR with err_code=01, no write at address 1, core_reset stays 0. Stream "[[+]" then 0x00 -> ERROR with err_code=10.
- addrSize=3: stream 8 '+' bytes -> 7 writes (addresses 0-6), the 8th byte gives err_code=11. Stream 7 '+' then 0x00 -> terminator at 7, RUN.
- Assert reset after 2 writes mid-load -> all outputs at reset values in the same cycle; a subsequent load_start plus a full program loads from address 0.
- load_start pulse while in RUN -> core_reset=0 the next cycle, ptr=0, and a new program overwrites from address 0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core and its code loader.
// Opcode bytes, loader states and loader error codes.
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_JZ    = 8'h5B;
    localparam logic [7:0] OP_JNZ   = 8'h5D;
    localparam logic [7:0] OP_HALT  = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TERM,
        S_RUN,
        S_ERROR
    } ld_state_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_UNMATCHED = 2'b01;
    localparam logic [1:0] ERR_UNCLOSED  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b11;

endpackage

// File: rtl/bf_opcode_filter.sv
// Classifies a received byte as a brainfuck instruction.
// Purely combinational; open/close flag the bracket opcodes.
module bf_opcode_filter
    import bf_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_is_instr,
    output logic       o_is_open,
    output logic       o_is_close
);

    always_comb begin
        o_is_instr = 1'b0;
        o_is_open  = 1'b0;
        o_is_close = 1'b0;
        unique case (i_byte)
            OP_INC, OP_DEC, OP_LEFT, OP_RIGHT, OP_OUT, OP_IN: begin
                o_is_instr = 1'b1;
            end
            OP_JZ: begin
                o_is_instr = 1'b1;
                o_is_open  = 1'b1;
            end
            OP_JNZ: begin
                o_is_instr = 1'b1;
                o_is_close = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bf_code_loader.sv
// Loads a streamed program into code RAM, checks brackets, appends
// a halt byte and releases the core once the program is complete.
module bf_code_loader
    import bf_pkg::*;
#(
    parameter int addrSize  = 9,
    parameter int depthSize = 8
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [addrSize-1:0] code_addr,
    output logic [7:0]          code_data,
    output logic                code_we,
    output logic                core_reset,
    output logic                load_done,
    output logic                load_error,
    output logic [1:0]          err_code,
    output logic [addrSize-1:0] prog_len
);

    localparam logic [addrSize-1:0]  PTR_MAX = {addrSize{1'b1}};
    localparam logic [depthSize-1:0] DEP_MAX = {depthSize{1'b1}};

    ld_state_t            r_state, w_state_n;
    logic [addrSize-1:0]  r_ptr, w_ptr_n;
    logic [depthSize-1:0] r_depth, w_depth_n;
    logic [addrSize-1:0]  r_addr, w_addr_n;
    logic [7:0]           r_data, w_data_n;
    logic                 r_we, w_we_n;
    logic [1:0]           r_err, w_err_n;
    logic [addrSize-1:0]  r_len, w_len_n;
    logic                 r_rx_ready;
    logic                 r_core_reset;
    logic                 r_load_done;
    logic                 r_load_error;

    logic w_is_instr, w_is_open, w_is_close;
    logic w_acc;

    bf_opcode_filter u_filter (
        .i_byte     (rx_data),
        .o_is_instr (w_is_instr),
        .o_is_open  (w_is_open),
        .o_is_close (w_is_close)
    );

    assign w_acc = (r_state == S_LOAD) & rx_valid & r_rx_ready;

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_depth_n = r_depth;
        w_addr_n  = r_addr;
        w_data_n  = r_data;
        w_we_n    = 1'b0;
        w_err_n   = r_err;
        w_len_n   = r_len;
        if (load_start) begin
            w_state_n = S_LOAD;
            w_ptr_n   = '0;
            w_depth_n = '0;
            w_err_n   = ERR_NONE;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_acc) begin
                        if (rx_data == OP_HALT) begin
                            w_state_n = S_TERM;
                        end else if (w_is_instr) begin
                            if (w_is_open && r_depth == DEP_MAX) begin
                                w_state_n = S_ERROR;
                                w_err_n   = ERR_OVERFLOW;
                            end else if (w_is_close && r_depth == '0) begin
                                w_state_n = S_ERROR;
                                w_err_n   = ERR_UNMATCHED;
                            end else if (r_ptr == PTR_MAX) begin
                                // last slot is reserved for the halt byte
                                w_state_n = S_ERROR;
                                w_err_n   = ERR_OVERFLOW;
                            end else begin
                                w_we_n   = 1'b1;
                                w_addr_n = r_ptr;
                                w_data_n = rx_data;
                                w_ptr_n  = r_ptr + 1'b1;
                                if (w_is_open)
                                    w_depth_n = r_depth + 1'b1;
                                else if (w_is_close)
                                    w_depth_n = r_depth - 1'b1;
                            end
                        end
                    end
                end
                S_TERM: begin
                    if (r_depth != '0) begin
                        w_state_n = S_ERROR;
                        w_err_n   = ERR_UNCLOSED;
                    end else begin
                        w_we_n    = 1'b1;
                        w_addr_n  = r_ptr;
                        w_data_n  = OP_HALT;
                        w_len_n   = r_ptr;
                        w_state_n = S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_depth      <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_err        <= ERR_NONE;
            r_len        <= '0;
            r_rx_ready   <= 1'b0;
            r_core_reset <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_ptr        <= w_ptr_n;
            r_depth      <= w_depth_n;
            r_addr       <= w_addr_n;
            r_data       <= w_data_n;
            r_we         <= w_we_n;
            r_err        <= w_err_n;
            r_len        <= w_len_n;
            r_rx_ready   <= (w_state_n == S_LOAD);
            // release the core one cycle after the halt byte is written
            r_core_reset <= (r_state == S_RUN) && (w_state_n == S_RUN);
            r_load_done  <= (w_state_n == S_RUN);
            r_load_error <= (w_state_n == S_ERROR);
        end
    end

    assign rx_ready   = r_rx_ready;
    assign code_addr  = r_addr;
    assign code_data  = r_data;
    assign code_we    = r_we;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;
    assign err_code   = r_err;
    assign prog_len   = r_len;

endmodule
